// File: rtl/linebuf_ring.sv
// linebuf_ring: ring of NUM_LINES line banks replayed with its own hsync/de timing.
// Compile with LINEBUF_DUP_EN defined to add the i_dup line-doubling port.
module linebuf_ring #(
   parameter  int NUM_LINES  = 4,
   parameter  int RGB_WIDTH  = 10,
   parameter  int ADDR_WIDTH = 6,
   parameter  int HOR_WIDTH  = 6,
   localparam int PW         = $clog2(NUM_LINES),
   localparam int LW         = PW + 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_vsync,
   input  logic                 i_de,
   input  logic [RGB_WIDTH-1:0] i_red,
   input  logic [RGB_WIDTH-1:0] i_green,
   input  logic [RGB_WIDTH-1:0] i_blue,
   input  logic [HOR_WIDTH-1:0] i_hsw,
   input  logic [HOR_WIDTH-1:0] i_hbp,
   input  logic [HOR_WIDTH-1:0] i_hact,
   input  logic [HOR_WIDTH-1:0] i_hfp,
   output logic                 o_hsync,
   output logic                 o_de,
   output logic [RGB_WIDTH-1:0] o_red,
   output logic [RGB_WIDTH-1:0] o_green,
   output logic [RGB_WIDTH-1:0] o_blue,
   output logic [LW-1:0]        o_level,
   output logic                 o_ovf
`ifdef LINEBUF_DUP_EN
   ,
   input  logic                 i_dup
`endif
);

   localparam int                 PXW  = 3 * RGB_WIDTH;
   localparam int                 MW   = PW + ADDR_WIDTH;
   localparam logic [LW-1:0]      FULL = LW'(NUM_LINES);
   localparam logic [ADDR_WIDTH-1:0] AMAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HSW,
      S_HBP,
      S_ACT,
      S_HFP
   } state_t;

   logic [PXW-1:0]        mem [2**MW];
   logic [PXW-1:0]        rd_data;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [LW-1:0]         level;
   logic                  de_q;
   state_t                state;
   logic [HOR_WIDTH-1:0]  cnt;
   logic [HOR_WIDTH-1:0]  hsw_n;
   logic [HOR_WIDTH-1:0]  hact_n;
   logic                  wr_en;
   logic                  commit;
   logic                  commit_ok;
   logic                  act_last;
   logic                  hold;
   logic                  pop;
   logic                  more;

`ifdef LINEBUF_DUP_EN
   logic phase;
   assign hold = i_dup & ~phase;
`else
   assign hold = 1'b0;
`endif

   // clamped durations minus one, loaded into the down-counter on entry
   assign hsw_n  = (i_hsw == '0) ? '0 : i_hsw - HOR_WIDTH'(1);
   assign hact_n = (i_hact == '0) ? '0 : i_hact - HOR_WIDTH'(1);

   assign wr_en     = i_de & ~i_vsync;
   assign commit    = de_q & ~i_de;
   assign act_last  = (state == S_ACT) && (cnt == '0);
   assign pop       = act_last & ~hold;
   assign commit_ok = commit & ((level != FULL) | pop);
   assign more      = pop ? (level > LW'(1)) : (level != '0);

   assign o_level = level;
   assign o_red   = o_de ? rd_data[PXW-1 -: RGB_WIDTH] : '0;
   assign o_green = o_de ? rd_data[RGB_WIDTH +: RGB_WIDTH] : '0;
   assign o_blue  = o_de ? rd_data[RGB_WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[{wr_ptr, wr_addr}] <= {i_red, i_green, i_blue};
      rd_data <= mem[{rd_ptr, rd_addr}];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         wr_addr <= '0;
         rd_addr <= '0;
         level   <= '0;
         de_q    <= 1'b0;
         state   <= S_IDLE;
         cnt     <= '0;
         o_hsync <= 1'b0;
         o_de    <= 1'b0;
         o_ovf   <= 1'b0;
`ifdef LINEBUF_DUP_EN
         phase   <= 1'b0;
`endif
      end else if (i_vsync) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         wr_addr <= '0;
         rd_addr <= '0;
         level   <= '0;
         de_q    <= 1'b0;
         state   <= S_IDLE;
         cnt     <= '0;
         o_hsync <= 1'b0;
         o_de    <= 1'b0;
         o_ovf   <= 1'b0;
`ifdef LINEBUF_DUP_EN
         phase   <= 1'b0;
`endif
      end else begin
         de_q    <= i_de;
         o_ovf   <= commit & ~commit_ok;
         o_hsync <= (state == S_HSW);
         o_de    <= (state == S_ACT);

         if (commit) begin
            wr_addr <= '0;
            if (commit_ok)
               wr_ptr <= wr_ptr + PW'(1);
         end else if (i_de && wr_addr != AMAX) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
         end

         if (commit_ok && !pop)
            level <= level + LW'(1);
         else if (!commit_ok && pop)
            level <= level - LW'(1);

         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

`ifdef LINEBUF_DUP_EN
         if (state == S_IDLE)
            phase <= 1'b0;
         else if (act_last && i_dup)
            phase <= ~phase;
`endif

         unique case (state)
            S_IDLE: begin
               if (level != '0) begin
                  state <= S_HSW;
                  cnt   <= hsw_n;
               end
            end
            S_HSW: begin
               if (cnt != '0) begin
                  cnt <= cnt - HOR_WIDTH'(1);
               end else if (i_hbp != '0) begin
                  state <= S_HBP;
                  cnt   <= i_hbp - HOR_WIDTH'(1);
               end else begin
                  state   <= S_ACT;
                  cnt     <= hact_n;
                  rd_addr <= '0;
               end
            end
            S_HBP: begin
               if (cnt != '0) begin
                  cnt <= cnt - HOR_WIDTH'(1);
               end else begin
                  state   <= S_ACT;
                  cnt     <= hact_n;
                  rd_addr <= '0;
               end
            end
            S_ACT: begin
               rd_addr <= rd_addr + ADDR_WIDTH'(1);
               if (cnt != '0) begin
                  cnt <= cnt - HOR_WIDTH'(1);
               end else if (i_hfp != '0) begin
                  state <= S_HFP;
                  cnt   <= i_hfp - HOR_WIDTH'(1);
               end else if (more) begin
                  state <= S_HSW;
                  cnt   <= hsw_n;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_HFP: begin
               if (cnt != '0) begin
                  cnt <= cnt - HOR_WIDTH'(1);
               end else if (level != '0) begin
                  state <= S_HSW;
                  cnt   <= hsw_n;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_linebuf_ring.sv
// tb_linebuf_ring: timing table, hand sequences and randomized replay
// of linebuf_ring against a queue-based line model.
module tb_linebuf_ring;

   localparam int NL  = 4;
   localparam int RW  = 10;
   localparam int AW  = 4;
   localparam int HW  = 6;
   localparam int CAP = 120;

   typedef struct {
      int hsw;
      int hbp;
      int hact;
      int hfp;
      int e_hs;
      int e_gap;
      int e_act;
      int e_per;
   } tvec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_vsync = 1'b0;
   logic          i_de = 1'b0;
   logic [RW-1:0] i_red = '0;
   logic [RW-1:0] i_green = '0;
   logic [RW-1:0] i_blue = '0;
   logic [HW-1:0] i_hsw = '0;
   logic [HW-1:0] i_hbp = '0;
   logic [HW-1:0] i_hact = '0;
   logic [HW-1:0] i_hfp = '0;
   logic          o_hsync;
   logic          o_de;
   logic [RW-1:0] o_red;
   logic [RW-1:0] o_green;
   logic [RW-1:0] o_blue;
   logic [2:0]    o_level;
   logic          o_ovf;
`ifdef LINEBUF_DUP_EN
   logic          i_dup = 1'b0;
`endif

   logic [3*RW-1:0] o_px;
   assign o_px = {o_red, o_green, o_blue};

   int n_vec = 0;
   int n_bad = 0;

   logic            tr_hs [CAP];
   logic            tr_de [CAP];
   logic [3*RW-1:0] tr_px [CAP];
   logic [2:0]      tr_lv [CAP];
   logic [3*RW-1:0] line_px [32];

   logic [3*RW-1:0] exp_px [$];
   int              exp_len [$];
   bit              mon_en = 1'b0;
   bit              prev_de = 1'b0;
   int              run_len = 0;

   linebuf_ring #(
      .NUM_LINES (NL),
      .RGB_WIDTH (RW),
      .ADDR_WIDTH(AW),
      .HOR_WIDTH (HW)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .i_vsync(i_vsync),
      .i_de   (i_de),
      .i_red  (i_red),
      .i_green(i_green),
      .i_blue (i_blue),
      .i_hsw  (i_hsw),
      .i_hbp  (i_hbp),
      .i_hact (i_hact),
      .i_hfp  (i_hfp),
      .o_hsync(o_hsync),
      .o_de   (o_de),
      .o_red  (o_red),
      .o_green(o_green),
      .o_blue (o_blue),
      .o_level(o_level),
      .o_ovf  (o_ovf)
`ifdef LINEBUF_DUP_EN
      ,
      .i_dup  (i_dup)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [3*RW-1:0] pix(input int v);
      return {RW'(v), RW'(v + 1), RW'(v + 2)};
   endfunction

   task automatic set_timing(input int a, input int b, input int c,
                             input int d);
      i_hsw  = HW'(a);
      i_hbp  = HW'(b);
      i_hact = HW'(c);
      i_hfp  = HW'(d);
   endtask

   task automatic flush();
      i_vsync = 1'b1;
      step();
      i_vsync = 1'b0;
      step();
   endtask

   task automatic write_line(input int n);
      for (int k = 0; k < n; k++) begin
         i_de = 1'b1;
         {i_red, i_green, i_blue} = line_px[k];
         step();
      end
      i_de = 1'b0;
      {i_red, i_green, i_blue} = '0;
      step();
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         tr_hs[i] = o_hsync;
         tr_de[i] = o_de;
         tr_px[i] = o_px;
         tr_lv[i] = o_level;
         step();
      end
   endtask

   // r-th high run of hsync (sel=1) or de (sel=0) in the trace
   function automatic void find_run(input bit sel, input int r,
                                    output int st, output int ln);
      int  c;
      bit  v;
      bit  p;
      c  = -1;
      st = -1;
      ln = 0;
      p  = 1'b0;
      for (int i = 0; i < CAP; i++) begin
         v = sel ? (tr_hs[i] === 1'b1) : (tr_de[i] === 1'b1);
         if (v && !p) begin
            c++;
            if (c == r)
               st = i;
         end
         if (v && c == r)
            ln++;
         p = v;
      end
   endfunction

   // line-level reference: each output de run must be the next queued line
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_de === 1'b1) begin
            if (exp_px.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rnd_extra: got pixel %0h want no output", o_px);
            end else begin
               chk("rnd_px", o_px, exp_px.pop_front());
            end
            run_len++;
         end else if (prev_de) begin
            if (exp_len.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rnd_run: got run %0d want none", run_len);
            end else begin
               chk("rnd_len", run_len, exp_len.pop_front());
            end
            run_len = 0;
         end
         prev_de = (o_de === 1'b1);
      end
   end

   initial begin
      tvec_t tbl [5];
      int r1, w1, d1, a1, r2, w2, lst;

      tbl[0] = '{2, 3, 8, 4, 2, 3, 8, 17};
      tbl[1] = '{0, 0, 6, 0, 1, 0, 6, 7};
      tbl[2] = '{1, 0, 4, 2, 1, 0, 4, 7};
      tbl[3] = '{3, 1, 0, 1, 3, 1, 1, 6};
      tbl[4] = '{5, 2, 10, 0, 5, 2, 10, 17};

      repeat (3) step();
      chk("rst_level", o_level, 0);
      chk("rst_hsync", o_hsync, 0);
      chk("rst_de", o_de, 0);
      chk("rst_ovf", o_ovf, 0);
      chk("rst_px", o_px, 0);
      rstn = 1'b1;
      step();
      chk("rst_idle_hs", o_hsync, 0);

      // basic replay
      set_timing(2, 3, 8, 4);
      for (int k = 0; k < 8; k++)
         line_px[k] = pix(16 * k + 1);
      write_line(8);
      capture(40);
      chk("bas_lv0", tr_lv[0], 1);
      chk("bas_hs1", tr_hs[1], 0);
      chk("bas_hs2", tr_hs[2], 1);
      chk("bas_hs3", tr_hs[3], 1);
      chk("bas_hs4", tr_hs[4], 0);
      chk("bas_px_idle", tr_px[5], 0);
      find_run(1'b0, 0, d1, a1);
      chk("bas_de_start", d1, 7);
      chk("bas_de_len", a1, 8);
      for (int k = 0; k < 8; k++)
         chk("bas_px", tr_px[7 + k], line_px[k]);
      chk("bas_lv13", tr_lv[13], 1);
      chk("bas_lv14", tr_lv[14], 0);

      // timing table
      for (int t = 0; t < 5; t++) begin
         flush();
         set_timing(tbl[t].hsw, tbl[t].hbp, tbl[t].hact, tbl[t].hfp);
         for (int k = 0; k < 4; k++)
            line_px[k] = pix(t * 64 + k * 4);
         write_line(4);
         fork
            capture(100);
            write_line(4);
         join
         find_run(1'b1, 0, r1, w1);
         find_run(1'b0, 0, d1, a1);
         find_run(1'b1, 1, r2, w2);
         chk("tbl_hs_w", w1, tbl[t].e_hs);
         chk("tbl_gap", d1 - (r1 + w1), tbl[t].e_gap);
         chk("tbl_act", a1, tbl[t].e_act);
         chk("tbl_period", r2 - r1, tbl[t].e_per);
      end

      // overflow, then commit coinciding with a pop
      flush();
      set_timing(63, 0, 4, 0);
      for (int l = 0; l < 5; l++) begin
         for (int k = 0; k < 4; k++)
            line_px[k] = pix(l * 8 + k);
         write_line(4);
         chk("ovf_level", o_level, (l < 4) ? l + 1 : 4);
         chk("ovf_pulse", o_ovf, (l == 4) ? 1 : 0);
      end
      step();
      chk("ovf_clear", o_ovf, 0);
      repeat (42) step();
      chk("pop_pre_level", o_level, 4);
      write_line(4);
      chk("pop_commit_level", o_level, 4);
      chk("pop_commit_ovf", o_ovf, 0);

      // truncation: 20 pixels into a 16-deep bank, then a neighbour line
      flush();
      set_timing(1, 0, 18, 0);
      for (int k = 0; k < 20; k++)
         line_px[k] = pix(k + 1);
      write_line(20);
      for (int k = 0; k < 4; k++)
         line_px[k] = pix(500 + k);
      fork
         capture(80);
         write_line(4);
      join
      find_run(1'b0, 0, d1, a1);
      chk("trc_len", a1, 18);
      for (int a = 0; a < 18; a++)
         chk("trc_px", tr_px[d1 + a], ((a % 16) < 15) ? pix((a % 16) + 1) : pix(20));
      find_run(1'b0, 1, d1, a1);
      for (int a = 0; a < 4; a++)
         chk("trc_nbr", tr_px[d1 + a], pix(500 + a));

      // flush mid-line
      flush();
      set_timing(1, 0, 8, 0);
      for (int k = 0; k < 8; k++)
         line_px[k] = pix(600 + 4 * k);
      write_line(8);
      for (int k = 0; k < 8; k++)
         line_px[k] = pix(700 + 4 * k);
      write_line(8);
      chk("fl_de_mid", o_de, 1);
      i_vsync = 1'b1;
      step();
      i_vsync = 1'b0;
      chk("fl_de", o_de, 0);
      chk("fl_level", o_level, 0);
      chk("fl_hs", o_hsync, 0);
      repeat (3) step();
      chk("fl_de_hold", o_de, 0);
      set_timing(1, 0, 4, 0);
      for (int k = 0; k < 4; k++)
         line_px[k] = pix(800 + 4 * k);
      write_line(4);
      capture(20);
      find_run(1'b0, 0, d1, a1);
      chk("fl_len", a1, 4);
      for (int k = 0; k < 4; k++)
         chk("fl_px", tr_px[d1 + k], pix(800 + 4 * k));

`ifdef LINEBUF_DUP_EN
      // line doubling: A,A,B,B
      flush();
      set_timing(1, 0, 4, 0);
      i_dup = 1'b1;
      for (int k = 0; k < 4; k++)
         line_px[k] = pix(900 + 4 * k);
      write_line(4);
      for (int k = 0; k < 4; k++)
         line_px[k] = pix(950 + 4 * k);
      fork
         capture(60);
         write_line(4);
      join
      for (int r = 0; r < 4; r++) begin
         find_run(1'b0, r, d1, a1);
         lst = d1 + a1 - 1;
         chk("dup_len", a1, 4);
         for (int k = 0; k < 4; k++)
            chk("dup_px", tr_px[d1 + k], pix(((r < 2) ? 900 : 950) + 4 * k));
         chk("dup_level", tr_lv[lst], (r == 0) ? 2 : ((r == 3) ? 0 : 1));
      end
      i_dup = 1'b0;
      repeat (10) step();
`endif

      // randomized lines against the queue model
      flush();
      mon_en = 1'b1;
      for (int r = 0; r < 25; r++) begin
         automatic int hs = $urandom_range(6, 0);
         automatic int hb = $urandom_range(4, 0);
         automatic int ha = $urandom_range(12, 0);
         automatic int hf = $urandom_range(4, 0);
         automatic int k  = $urandom_range(4, 1);
         automatic int eff = (ha == 0) ? 1 : ha;
         automatic int guard = 0;
         set_timing(hs, hb, ha, hf);
         for (int l = 0; l < k; l++) begin
            automatic int len = $urandom_range(16, eff);
            for (int p = 0; p < len; p++)
               line_px[p] = (3 * RW)'($urandom);
            for (int p = 0; p < eff; p++)
               exp_px.push_back(line_px[p]);
            exp_len.push_back(eff);
            write_line(len);
            repeat ($urandom_range(4, 0)) step();
         end
         while ((exp_px.size() != 0 || exp_len.size() != 0) && guard < 1000) begin
            step();
            guard++;
         end
         chk("rnd_drain", exp_len.size(), 0);
         repeat (12) step();
         chk("rnd_level", o_level, 0);
      end
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
